// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing generator.
//   CNT_W         - width of the horizontal/vertical position counters
//   DEF_*         - default 640x480@60 (25 MHz pixel clock) timing
//   run_state_e   - run/halt state of the frame sequencer
//   axis_total()  - total length of one axis (active + porches + sync)
package vga_pkg;

    localparam int CNT_W   = 12;
    localparam int MAX_TOT = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: position counter for one display axis.
// The counter runs 0..TOT-1 in the order active, front porch, sync,
// back porch, stepping once per cycle while 'advance' is high.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   advance     - step the counter this cycle
//   cnt         - current position
//   cnt_nxt     - position after this cycle's edge
//   active_nxt  - cnt_nxt lies in the active region
//   sync_nxt    - cnt_nxt lies in the sync region
//   wrap        - counter steps from TOT-1 back to 0 at this edge
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             active_nxt,
    output logic             sync_nxt,
    output logic             wrap
);

    localparam int TOT = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOT - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        wrap  = advance && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (advance) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Region flags look at the next count so the parent can register
    // them in step with the counter itself.
    assign cnt        = cnt_q;
    assign cnt_nxt    = cnt_d;
    assign active_nxt = (cnt_d < ACT_END);
    assign sync_nxt   = (cnt_d >= SYNC_START) && (cnt_d < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a pixel-fetch interface.
// A request stage (pix_req, pix_x/pix_y, frame_start, vblank_irq) tells a
// pixel source what to fetch; the source answers PIX_LAT cycles later on
// pix_data and the video outputs appear PIX_LAT+1 cycles after the request,
// with de, rgb and both syncs mutually aligned.
// Ports:
//   clk25M, rst         - pixel clock, asynchronous active-high reset
//   enable              - run request; a falling enable halts at frame end
//   pix_data            - pixel from the source
//   pattern_sel         - (VGA_TESTPAT_EN only) show 8 vertical colour bars
//   pix_req, pix_x/y    - fetch request and its active-area coordinates
//   frame_start         - pulse at position (0,0)
//   vblank_irq          - pulse at the first vertical blanking line
//   vga_hsync/vsync/de  - video timing outputs
//   vga_rgb             - video data, zero outside the active area
// Optional feature macro: VGA_TESTPAT_EN (built-in colour bar pattern).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   RGB_W     = 3,
    parameter int   PIX_LAT   = 1
) (
    input  logic             clk25M,
    input  logic             rst,
    input  logic             enable,
    input  logic [RGB_W-1:0] pix_data,
`ifdef VGA_TESTPAT_EN
    input  logic             pattern_sel,
`endif
    output logic             pix_req,
    output logic [11:0]      pix_x,
    output logic [11:0]      pix_y,
    output logic             frame_start,
    output logic             vblank_irq,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_de,
    output logic [RGB_W-1:0] vga_rgb
);

    localparam int HTOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VTOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] V_ACT_CNT = CNT_W'(V_ACTIVE);

    if (HTOT > MAX_TOT || VTOT > MAX_TOT) begin : g_bad_total
        $error("vga_timing_gen: HTOT/VTOT exceeds counter range");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: timing parameters must be non-zero");
    end
    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
        $error("vga_timing_gen: PIX_LAT must be 1..4");
    end

    run_state_e state_q, state_d;

    logic             h_run;
    logic             run_d;
    logic [CNT_W-1:0] h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
    logic             h_act_nxt, h_sync_nxt, h_wrap;
    logic             v_act_nxt, v_sync_nxt, v_wrap;

    logic pix_req_q, pix_req_d;
    logic frame_start_q, frame_start_d;
    logic vblank_q, vblank_d;
    logic hsync_on_q, hsync_on_d;
    logic vsync_on_q, vsync_on_d;

    logic [PIX_LAT:0] de_sr_q, de_sr_d;
    logic [PIX_LAT:0] hs_sr_q, hs_sr_d;
    logic [PIX_LAT:0] vs_sr_q, vs_sr_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    assign h_run = (state_q == ST_RUN);

    vga_axis_timer #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_timer (
        .clk(clk25M), .rst(rst), .advance(h_run),
        .cnt(h_cnt), .cnt_nxt(h_cnt_nxt),
        .active_nxt(h_act_nxt), .sync_nxt(h_sync_nxt), .wrap(h_wrap)
    );

    // The vertical counter steps once per completed line; its wrap marks
    // the last cycle of the frame.
    vga_axis_timer #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_timer (
        .clk(clk25M), .rst(rst), .advance(h_wrap),
        .cnt(v_cnt), .cnt_nxt(v_cnt_nxt),
        .active_nxt(v_act_nxt), .sync_nxt(v_sync_nxt), .wrap(v_wrap)
    );

    // enable is only honoured at frame boundaries while running, so a
    // short drop inside a frame never halts the raster. Halting happens
    // exactly as the counters wrap, leaving them parked at (0,0).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: if (enable) state_d = ST_RUN;
            ST_RUN:  if (v_wrap && !enable) state_d = ST_HALT;
        endcase
    end

    // Request-stage flags are computed from next-state values so that
    // they become registered in the same cycle as the position they
    // describe.
    always_comb begin
        run_d         = (state_d == ST_RUN);
        pix_req_d     = run_d && h_act_nxt && v_act_nxt;
        frame_start_d = run_d && (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
        vblank_d      = run_d && (h_cnt_nxt == '0) && (v_cnt_nxt == V_ACT_CNT);
        hsync_on_d    = run_d && h_sync_nxt;
        vsync_on_d    = run_d && v_sync_nxt;
    end

`ifdef VGA_TESTPAT_EN
    logic [PIX_LAT-1:0][2:0] bar_sr_q, bar_sr_d;
    logic [2:0]              bar_now;

    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        for (int i = 0; i < RGB_W; i++) begin
            bar_colour[i] = idx[i % 3];
        end
    endfunction

    // Bar index travels beside de so it lines up with the source's data.
    always_comb begin
        bar_now     = 3'(({h_cnt, 3'b000}) / (CNT_W + 3)'(H_ACTIVE));
        bar_sr_d    = bar_sr_q;
        bar_sr_d[0] = bar_now;
        for (int i = 1; i < PIX_LAT; i++) begin
            bar_sr_d[i] = bar_sr_q[i-1];
        end
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            bar_sr_q <= '0;
        end else begin
            bar_sr_q <= bar_sr_d;
        end
    end
`endif

    // de/hsync/vsync delay lines; tap PIX_LAT-1 lines up with pix_data
    // arriving from the source, tap PIX_LAT with the registered rgb.
    always_comb begin
        de_sr_d = {de_sr_q[PIX_LAT-1:0], pix_req_q};
        hs_sr_d = {hs_sr_q[PIX_LAT-1:0], hsync_on_q};
        vs_sr_d = {vs_sr_q[PIX_LAT-1:0], vsync_on_q};
        rgb_d   = '0;
        if (de_sr_q[PIX_LAT-1]) begin
            rgb_d = pix_data;
`ifdef VGA_TESTPAT_EN
            if (pattern_sel) begin
                rgb_d = bar_colour(bar_sr_q[PIX_LAT-1]);
            end
`endif
        end
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HALT;
            pix_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_on_q    <= 1'b0;
            vsync_on_q    <= 1'b0;
            de_sr_q       <= '0;
            hs_sr_q       <= '0;
            vs_sr_q       <= '0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            pix_req_q     <= pix_req_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            hsync_on_q    <= hsync_on_d;
            vsync_on_q    <= vsync_on_d;
            de_sr_q       <= de_sr_d;
            hs_sr_q       <= hs_sr_d;
            vs_sr_q       <= vs_sr_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pix_req     = pix_req_q;
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign frame_start = frame_start_q;
    assign vblank_irq  = vblank_q;
    assign vga_de      = de_sr_q[PIX_LAT];
    assign vga_rgb     = rgb_q;
    assign vga_hsync   = hs_sr_q[PIX_LAT] ? HSYNC_POL : ~HSYNC_POL;
    assign vga_vsync   = vs_sr_q[PIX_LAT] ? VSYNC_POL : ~VSYNC_POL;

endmodule
